// File: rtl/axi4l_pkg.sv
// rtl/axi4l_pkg.sv - AXI4-Lite response codes and register-slave FSM state types
package axi4l_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi4l_resp_t;

  typedef enum logic {W_IDLE, W_RESP} axi4l_wstate_t;
  typedef enum logic {R_IDLE, R_DATA} axi4l_rstate_t;

endpackage

// File: rtl/axi4l_if.sv
// rtl/axi4l_if.sv - AXI4-Lite bus bundle with master/slave modports
interface axi4l_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4l_strb_merge.sv
// rtl/axi4l_strb_merge.sv - byte-strobe merge of new write data over the old register word
module axi4l_strb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_data,
  input  logic [DATA_WIDTH-1:0]   new_data,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   merged
);

  always_comb begin
    merged = old_data;
    for (int k = 0; k < DATA_WIDTH/8; k++) begin
      if (strb[k]) merged[k*8 +: 8] = new_data[k*8 +: 8];
    end
  end

endmodule

// File: rtl/axi4l_reg_slave.sv
// rtl/axi4l_reg_slave.sv - AXI4-Lite register bank; AXI4L_REG_SLAVE_PROT_CHECK_EN rejects unprivileged accesses
module axi4l_reg_slave
  import axi4l_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           aclk,
  input  logic                           areset,
  axi4l_if.slave                         s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = ADDR_WIDTH - ADDR_LSB;

  axi4l_wstate_t w_state, w_next;
  axi4l_rstate_t r_state, r_next;

  logic                  aw_held, w_held, aw_priv;
  logic [IDX_WIDTH-1:0]  aw_idx, ar_idx;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q, wr_old, wr_merged, rd_val;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  axi4l_resp_t           bresp_q, rresp_q;
  logic                  awready_i, wready_i, bvalid_i, arready_i, rvalid_i;
  logic                  commit, aw_hs, w_hs, b_hs, ar_hs, wr_ok, rd_ok;
  logic                  unused_bits;

  function automatic logic idx_in_range(input logic [IDX_WIDTH-1:0] idx);
    return {1'b0, idx} < (IDX_WIDTH+1)'(NUM_REGS);
  endfunction

  assign ar_idx = s_axi.araddr[ADDR_WIDTH-1:ADDR_LSB];

`ifdef AXI4L_REG_SLAVE_PROT_CHECK_EN
  assign wr_ok = idx_in_range(aw_idx) && aw_priv;
  assign rd_ok = idx_in_range(ar_idx) && s_axi.arprot[0];
`else
  assign wr_ok = idx_in_range(aw_idx);
  assign rd_ok = idx_in_range(ar_idx);
`endif

  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, aw_priv,
                         s_axi.awaddr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // Commit fires one cycle after both AW and W are held, so the later handshake sees a full cycle of setup.
  always_comb begin
    w_next    = w_state;
    commit    = 1'b0;
    awready_i = 1'b0;
    wready_i  = 1'b0;
    bvalid_i  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready_i = !aw_held;
        wready_i  = !w_held;
        if (aw_held && w_held) begin
          commit = 1'b1;
          w_next = W_RESP;
        end
      end
      W_RESP: begin
        bvalid_i = 1'b1;
        if (s_axi.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next    = r_state;
    arready_i = 1'b0;
    rvalid_i  = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready_i = 1'b1;
        if (s_axi.arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        rvalid_i = 1'b1;
        if (s_axi.rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign aw_hs = s_axi.awvalid && awready_i;
  assign w_hs  = s_axi.wvalid && wready_i;
  assign b_hs  = bvalid_i && s_axi.bready;
  assign ar_hs = s_axi.arvalid && arready_i;

  always_comb begin
    rd_val = '0;
    wr_old = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_WIDTH'(i)) rd_val = regs[i];
      if (aw_idx == IDX_WIDTH'(i)) wr_old = regs[i];
    end
  end

  axi4l_strb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_strb_merge (
    .old_data (wr_old),
    .new_data (wdata_q),
    .strb     (wstrb_q),
    .merged   (wr_merged)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      aw_priv <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= OKAY;
      reg_wr  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      reg_wr <= '0;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axi.awaddr[ADDR_WIDTH-1:ADDR_LSB];
        aw_priv <= s_axi.awprot[0];
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end
      if (commit) begin
        bresp_q <= wr_ok ? OKAY : SLVERR;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wr_ok && aw_idx == IDX_WIDTH'(i)) begin
            regs[i]   <= wr_merged;
            reg_wr[i] <= 1'b1;
          end
        end
      end
      if (b_hs) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  // Sampling the bank at the AR edge gives a same-edge write's pre-write value.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_ok ? rd_val : '0;
      rresp_q <= rd_ok ? OKAY : SLVERR;
    end
  end

  assign s_axi.awready = awready_i;
  assign s_axi.wready  = wready_i;
  assign s_axi.bvalid  = bvalid_i;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_i;
  assign s_axi.rvalid  = rvalid_i;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule
